// File: rtl/reg_file_flags_pkg.sv
// rtl/reg_file_flags_pkg.sv - shared widths, zero-register index and flag bit positions
package reg_file_flags_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 3;
  localparam int REG_ZERO   = 0;
  localparam int FLAG_Z     = 0;
  localparam int FLAG_C     = 1;

endpackage

// File: rtl/reg_file_flags_flag_reg.sv
// rtl/reg_file_flags_flag_reg.sv - C/Z flag register with one-level shadow save/restore
module reg_file_flags_flag_reg
  import reg_file_flags_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic flag_we_z,
  input  logic flag_we_c,
  input  logic zero_in,
  input  logic carry_in_alu,
  input  logic flag_save,
  input  logic flag_restore,
  output logic carry_q,
  output logic zero_q
);

  logic [1:0] flags;
  logic [1:0] shadow;

  // Save samples the pre-edge flags, so save+restore on one edge swaps live and shadow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags  <= 2'b00;
      shadow <= 2'b00;
    end else begin
      if (flag_save) shadow <= flags;
      if (flag_restore) begin
        flags <= shadow;
      end else begin
        if (flag_we_z) flags[FLAG_Z] <= zero_in;
        if (flag_we_c) flags[FLAG_C] <= carry_in_alu;
      end
    end
  end

  assign carry_q = flags[FLAG_C];
  assign zero_q  = flags[FLAG_Z];

endmodule

// File: rtl/reg_file_flags.sv
// rtl/reg_file_flags.sv - 8x8 register file with write-through read ports and ALU C/Z flags
module reg_file_flags
  import reg_file_flags_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NREGS  = 1 << ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] ra_addr,
  input  logic [ADDR_W-1:0] rb_addr,
  output logic [DATA_W-1:0] rd_a,
  output logic [DATA_W-1:0] rd_b,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              flag_we_z,
  input  logic              flag_we_c,
  input  logic              zero_in,
  input  logic              carry_in_alu,
  input  logic              flag_save,
  input  logic              flag_restore,
  output logic              carry_q,
  output logic              zero_q
);

  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0] regs [NREGS];
  logic              wr_hit;

  assign wr_hit = wr_en && (wr_addr != ZERO_ADDR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wr_hit) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // r0 wins over bypass, so a discarded write to r0 never leaks onto a read port.
  always_comb begin
    rd_a = regs[ra_addr];
    if (ra_addr == ZERO_ADDR)             rd_a = '0;
    else if (wr_hit && ra_addr == wr_addr) rd_a = wr_data;
  end

  always_comb begin
    rd_b = regs[rb_addr];
    if (rb_addr == ZERO_ADDR)             rd_b = '0;
    else if (wr_hit && rb_addr == wr_addr) rd_b = wr_data;
  end

  reg_file_flags_flag_reg u_flag_reg (
    .clk          (clk),
    .rst_n        (rst_n),
    .flag_we_z    (flag_we_z),
    .flag_we_c    (flag_we_c),
    .zero_in      (zero_in),
    .carry_in_alu (carry_in_alu),
    .flag_save    (flag_save),
    .flag_restore (flag_restore),
    .carry_q      (carry_q),
    .zero_q       (zero_q)
  );

endmodule

// File: tb/tb_reg_file_flags.sv
// tb/tb_reg_file_flags.sv - scoreboard bench for reg_file_flags against a behavioural model
module tb_reg_file_flags;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] ra_addr = '0, rb_addr = '0, wr_addr = '0;
  logic [7:0] rd_a, rd_b, wr_data = '0;
  logic       wr_en = 1'b0, flag_we_z = 1'b0, flag_we_c = 1'b0, zero_in = 1'b0;
  logic       carry_in_alu = 1'b0, flag_save = 1'b0, flag_restore = 1'b0;
  logic       carry_q, zero_q;

  reg_file_flags dut (
    .clk(clk), .rst_n(rst_n), .ra_addr(ra_addr), .rb_addr(rb_addr),
    .rd_a(rd_a), .rd_b(rd_b), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .flag_we_z(flag_we_z), .flag_we_c(flag_we_c), .zero_in(zero_in),
    .carry_in_alu(carry_in_alu), .flag_save(flag_save), .flag_restore(flag_restore),
    .carry_q(carry_q), .zero_q(zero_q)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       c;
    logic       z;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference state: what the architectural registers and flags hold.
  logic [7:0] m_reg [8];
  logic       m_c, m_z, m_sc, m_sz;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, want, $time);
    end
  endtask

  function automatic logic [7:0] model_read(input logic [2:0] addr, input logic we,
                                            input logic [2:0] wa, input logic [7:0] wd);
    if (addr == 3'd0) return 8'h00;
    if (we && wa != 3'd0 && wa == addr) return wd;
    return m_reg[addr];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_reg[i] = 8'h00;
    m_c = 0; m_z = 0; m_sc = 0; m_sz = 0;
  endtask

  task automatic drive(input logic we, input logic [2:0] wa, input logic [7:0] wd,
                       input logic [2:0] a, input logic [2:0] b,
                       input logic wz, input logic wc, input logic zi, input logic ci,
                       input logic sv, input logic rs);
    exp_t e;
    logic old_c, old_z;
    @(negedge clk);
    wr_en = we; wr_addr = wa; wr_data = wd; ra_addr = a; rb_addr = b;
    flag_we_z = wz; flag_we_c = wc; zero_in = zi; carry_in_alu = ci;
    flag_save = sv; flag_restore = rs;
    e.a = model_read(a, we, wa, wd);
    e.b = model_read(b, we, wa, wd);
    e.c = m_c;
    e.z = m_z;
    exp_q.push_back(e);
    @(posedge clk);
    old_c = m_c; old_z = m_z;
    if (we && wa != 3'd0) m_reg[wa] = wd;
    if (rs) begin
      m_c = m_sc; m_z = m_sz;
    end else begin
      if (wz) m_z = zi;
      if (wc) m_c = ci;
    end
    if (sv) begin
      m_sc = old_c; m_sz = old_z;
    end
  endtask

  task automatic idle(input logic [2:0] a, input logic [2:0] b);
    drive(0, 3'd0, 8'h00, a, b, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: every cycle with pending stimulus, compare the settled outputs before the edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("rd_a", rd_a, e.a);
        chk("rd_b", rd_b, e.b);
        chk("carry_q", {7'd0, carry_q}, {7'd0, e.c});
        chk("zero_q", {7'd0, zero_q}, {7'd0, e.z});
      end
    end
  end

  initial begin
    model_reset();
    #3;
    chk("reset_rd_a", rd_a, 8'h00);
    chk("reset_rd_b", rd_b, 8'h00);
    chk("reset_carry", {7'd0, carry_q}, 8'h00);
    chk("reset_zero", {7'd0, zero_q}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // Write/read and r0 immunity
    drive(1, 3'd3, 8'hA5, 3'd3, 3'd7, 0, 0, 0, 0, 0, 0);
    drive(1, 3'd7, 8'h3C, 3'd3, 3'd7, 0, 0, 0, 0, 0, 0);
    idle(3'd3, 3'd7);
    drive(1, 3'd0, 8'hFF, 3'd0, 3'd0, 0, 0, 0, 0, 0, 0);
    idle(3'd0, 3'd3);

    // Bypass on both ports, then the stored value
    drive(1, 3'd5, 8'h81, 3'd5, 3'd5, 0, 0, 0, 0, 0, 0);
    idle(3'd5, 3'd5);

    // Flag write, hold, Z write
    drive(0, 3'd0, 8'h00, 3'd1, 3'd2, 0, 1, 0, 1, 0, 0);
    drive(0, 3'd0, 8'h00, 3'd1, 3'd2, 0, 0, 0, 0, 0, 0);
    drive(0, 3'd0, 8'h00, 3'd1, 3'd2, 1, 0, 1, 0, 0, 0);
    idle(3'd1, 3'd2);

    // Save/restore with restore beating flag_we_c
    drive(0, 3'd0, 8'h00, 3'd0, 3'd0, 1, 1, 0, 1, 0, 0);
    drive(0, 3'd0, 8'h00, 3'd0, 3'd0, 0, 0, 0, 0, 1, 0);
    drive(0, 3'd0, 8'h00, 3'd0, 3'd0, 1, 1, 1, 0, 0, 0);
    drive(0, 3'd0, 8'h00, 3'd0, 3'd0, 0, 1, 0, 0, 0, 1);
    idle(3'd0, 3'd0);

    // Swap: shadow {C,Z}=01, live 10, then save+restore, then restore to expose the shadow
    drive(0, 3'd0, 8'h00, 3'd0, 3'd0, 1, 1, 1, 0, 0, 0);
    drive(0, 3'd0, 8'h00, 3'd0, 3'd0, 0, 0, 0, 0, 1, 0);
    drive(0, 3'd0, 8'h00, 3'd0, 3'd0, 1, 1, 0, 1, 0, 0);
    drive(0, 3'd0, 8'h00, 3'd0, 3'd0, 0, 0, 0, 0, 1, 1);
    drive(0, 3'd0, 8'h00, 3'd0, 3'd0, 0, 0, 0, 0, 0, 1);
    idle(3'd0, 3'd0);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 3) != 0, 3'($urandom), 8'($urandom),
            3'($urandom), 3'($urandom),
            1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
    end

    // Asynchronous reset in the middle of a cycle, after state has been built up
    drive(1, 3'd6, 8'h5A, 3'd6, 3'd6, 1, 1, 1, 1, 0, 0);
    drive(0, 3'd0, 8'h00, 3'd6, 3'd6, 0, 0, 0, 0, 1, 0);
    @(negedge clk);
    wr_en = 1'b0; flag_we_z = 1'b0; flag_we_c = 1'b0; flag_save = 1'b0; flag_restore = 1'b0;
    #4;
    rst_n = 1'b0;
    #1;
    chk("async_carry", {7'd0, carry_q}, 8'h00);
    chk("async_zero", {7'd0, zero_q}, 8'h00);
    for (int i = 0; i < 8; i++) begin
      ra_addr = 3'(i);
      rb_addr = 3'(7 - i);
      #1;
      chk("async_rd_a", rd_a, 8'h00);
      chk("async_rd_b", rd_b, 8'h00);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 3'd0, 8'h00, 3'd0, 3'd0, 0, 0, 0, 0, 0, 1);
    drive(1, 3'd4, 8'hC3, 3'd6, 3'd4, 1, 0, 1, 0, 0, 0);
    idle(3'd4, 3'd6);

    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
